// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the parametrised Sudoku board engine.
// The cell value field is sized for boards up to BOX=4 (16 digits).
package sudoku_pkg;

  localparam int STATE_W = 3;
  localparam int VW_MAX  = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_CHECK = 3'd3,
    ST_WON   = 3'd4
  } state_t;

  typedef struct packed {
    logic              locked;
    logic              filled;
    logic [VW_MAX-1:0] value;
  } cell_t;

  // Reference solution: row r is the base sequence shifted by BOX*(r%BOX)+r/BOX.
  function automatic int sol(input int box, input int r, input int c);
    return (box * (r % box) + r / box + c) % (box * box);
  endfunction

  // Whether cell (r,c) is preloaded and locked for a given difficulty.
  function automatic logic given(input logic [1:0] diff, input int r, input int c);
    case (diff)
      2'd0:    return (r != c);
      2'd1:    return ((r + c) % 2) == 0;
      2'd2:    return (r == c);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sudoku_group_checker.sv
// Combinational check of one Sudoku group (row, column or box).
// Group index 0..N-1 selects rows, N..2N-1 columns, 2N..3N-1 boxes.
// A group passes when its values cover every digit exactly; codes >= N
// shift out of the mask and therefore make the group fail.
module sudoku_group_checker
  import sudoku_pkg::*;
#(
  parameter  int BOX = 2,
  localparam int N   = BOX * BOX,
  localparam int GW  = $clog2(3 * N)
) (
  input  logic [GW-1:0]          group_idx,
  input  logic [N*N*VW_MAX-1:0]  board_vals,
  output logic                   pass
);

  int                g_i;
  int                r_i;
  int                c_i;
  int                cell_i;
  logic [VW_MAX-1:0] v;
  logic [N-1:0]      acc;

  // Gather the N cells of the selected group and OR their one-hot digits.
  always_comb begin
    g_i    = int'(group_idx);
    r_i    = 0;
    c_i    = 0;
    cell_i = 0;
    v      = '0;
    acc    = '0;
    for (int k = 0; k < N; k++) begin
      if (g_i < N) begin
        r_i = g_i;
        c_i = k;
      end else if (g_i < 2 * N) begin
        r_i = k;
        c_i = g_i - N;
      end else begin
        r_i = ((g_i - 2 * N) / BOX) * BOX + k / BOX;
        c_i = ((g_i - 2 * N) % BOX) * BOX + k % BOX;
      end
      cell_i = r_i * N + c_i;
      if (cell_i >= N * N) cell_i = 0;
      v   = board_vals[cell_i*VW_MAX +: VW_MAX];
      acc = acc | (N'(1) << v);
    end
  end

  assign pass = &acc;

endmodule

// File: rtl/sudoku_board_engine.sv
// N x N Sudoku board engine: preload, player entry/erase, full-board check.
// Optional build macro SUDOKU_ERR_CNT_EN adds an 8-bit saturating error
// counter output (out_err_count).
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   IDLE  0  | waiting for in_start
//   LOAD  1  | writing one cell per cycle from the solution/givens
//   PLAY  2  | accepting player entries and erases
//   CHECK 3  | scanning one group per cycle, rows then cols then boxes
//   WON   4  | board solved; in_start begins a new game
module sudoku_board_engine
  import sudoku_pkg::*;
#(
  parameter  int BOX = 2,
  localparam int N   = BOX * BOX,
  localparam int VW  = $clog2(N),
  localparam int IW  = $clog2(N * N)
) (
  input  logic          in_clka,
  input  logic          in_restart,
  input  logic          in_start,
  input  logic [1:0]    in_difficulty,
  input  logic          in_enter,
  input  logic          in_erase,
  input  logic [IW-1:0] in_cell_idx,
  input  logic [VW-1:0] in_value,
  output logic [2:0]    out_state,
  output logic [IW:0]   out_fill_count,
  output logic          out_try_again,
`ifdef SUDOKU_ERR_CNT_EN
  output logic [7:0]    out_err_count,
`endif
  output logic          out_won
);

  localparam int NN = N * N;
  localparam int FW = IW + 1;
  localparam int GW = $clog2(3 * N);

  state_t              state_q, state_d;
  logic [1:0]          diff_q;
  logic [VW-1:0]       load_r, load_c;
  logic [GW-1:0]       grp_q;
  logic                fail_q;
  logic                go_check_q;
  logic [FW-1:0]       fill_q, fill_next;
  logic                try_q;
  cell_t               board_q [NN];
  logic [NN*VW_MAX-1:0] board_vals;

  logic          start_ok, load_last, idx_ok, sel_locked, sel_filled;
  logic          enter_act, reject, accept, grp_pass, check_last, check_fail;
  logic          try_d;
  logic [IW-1:0] load_idx;
  cell_t         load_cell;

  sudoku_group_checker #(.BOX(BOX)) u_checker (
    .group_idx  (grp_q),
    .board_vals (board_vals),
    .pass       (grp_pass)
  );

  // Flatten stored values for the group checker.
  always_comb begin
    board_vals = '0;
    for (int i = 0; i < NN; i++) board_vals[i*VW_MAX +: VW_MAX] = board_q[i].value;
  end

  // Decode of the current request and the next fill count.
  always_comb begin
    start_ok   = in_start && (state_q == ST_IDLE || state_q == ST_WON);
    load_last  = (load_r == VW'(N - 1)) && (load_c == VW'(N - 1));
    load_idx   = IW'(int'(load_r) * N + int'(load_c));
    load_cell.locked = given(diff_q, int'(load_r), int'(load_c));
    load_cell.filled = load_cell.locked;
    load_cell.value  = VW_MAX'(sol(BOX, int'(load_r), int'(load_c)));
    idx_ok     = {1'b0, in_cell_idx} < FW'(NN);
    sel_locked = idx_ok ? board_q[in_cell_idx].locked : 1'b0;
    sel_filled = idx_ok ? board_q[in_cell_idx].filled : 1'b0;
    // A full-board entry is still pending its check; entries wait until it runs.
    enter_act  = in_enter && (state_q == ST_PLAY) && !go_check_q;
    reject     = enter_act && (!idx_ok || sel_locked);
    accept     = enter_act && !reject;
    fill_next  = fill_q;
    if (accept && in_erase && sel_filled)        fill_next = fill_q - FW'(1);
    else if (accept && !in_erase && !sel_filled) fill_next = fill_q + FW'(1);
    check_last = (state_q == ST_CHECK) && (grp_q == GW'(3 * N - 1));
    check_fail = fail_q || !grp_pass;
    try_d      = reject || (check_last && check_fail);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_start) state_d = ST_LOAD;
      ST_LOAD:  if (load_last) state_d = ST_PLAY;
      ST_PLAY:  if (go_check_q) state_d = ST_CHECK;
      ST_CHECK: if (check_last) state_d = check_fail ? ST_PLAY : ST_WON;
      ST_WON:   if (in_start) state_d = ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge in_clka or posedge in_restart) begin
    if (in_restart) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Board contents, fill count and load sequencing.
  always_ff @(posedge in_clka or posedge in_restart) begin
    if (in_restart) begin
      for (int i = 0; i < NN; i++) board_q[i] <= '0;
      fill_q     <= '0;
      diff_q     <= '0;
      load_r     <= '0;
      load_c     <= '0;
      go_check_q <= 1'b0;
    end else begin
      go_check_q <= accept && (fill_next == FW'(NN));
      if (start_ok) begin
        diff_q <= in_difficulty;
        load_r <= '0;
        load_c <= '0;
        fill_q <= '0;
      end else if (state_q == ST_LOAD) begin
        board_q[load_idx] <= load_cell;
        if (load_cell.filled) fill_q <= fill_q + FW'(1);
        if (load_c == VW'(N - 1)) begin
          load_c <= '0;
          load_r <= load_r + VW'(1);
        end else begin
          load_c <= load_c + VW'(1);
        end
      end else if (accept) begin
        if (in_erase) begin
          board_q[in_cell_idx].filled <= 1'b0;
        end else begin
          board_q[in_cell_idx].filled <= 1'b1;
          board_q[in_cell_idx].value  <= VW_MAX'(in_value);
        end
        fill_q <= fill_next;
      end
    end
  end

  // Group scan: always visits all 3N groups, first failure is sticky.
  always_ff @(posedge in_clka or posedge in_restart) begin
    if (in_restart) begin
      grp_q  <= '0;
      fail_q <= 1'b0;
    end else if (state_q == ST_CHECK) begin
      grp_q  <= grp_q + GW'(1);
      fail_q <= check_fail;
    end else begin
      grp_q  <= '0;
      fail_q <= 1'b0;
    end
  end

  // One-cycle try-again pulse for rejected entries and failed checks.
  always_ff @(posedge in_clka or posedge in_restart) begin
    if (in_restart) try_q <= 1'b0;
    else            try_q <= try_d;
  end

`ifdef SUDOKU_ERR_CNT_EN
  logic [7:0] err_q;

  // Saturating count of try-again events, cleared when a new game starts.
  always_ff @(posedge in_clka or posedge in_restart) begin
    if (in_restart)                    err_q <= '0;
    else if (start_ok)                 err_q <= '0;
    else if (try_d && err_q != 8'hFF)  err_q <= err_q + 8'd1;
  end

  assign out_err_count = err_q;
`endif

  assign out_state      = state_q;
  assign out_fill_count = fill_q;
  assign out_try_again  = try_q;
  assign out_won        = (state_q == ST_WON);

endmodule

// File: tb/tb_sudoku_board_engine.sv
// Directed bench for sudoku_board_engine: a BOX=2 instance and a BOX=3 instance.
module tb_sudoku_board_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       a_start, a_enter, a_erase;
  logic [1:0] a_diff;
  logic [3:0] a_idx;
  logic [1:0] a_val;
  logic [2:0] a_state;
  logic [4:0] a_fill;
  logic       a_try, a_won;

  logic       b_start, b_enter, b_erase;
  logic [1:0] b_diff;
  logic [6:0] b_idx;
  logic [3:0] b_val;
  logic [2:0] b_state;
  logic [7:0] b_fill;
  logic       b_try, b_won;

`ifdef SUDOKU_ERR_CNT_EN
  logic [7:0] a_err, b_err;
`endif

  sudoku_board_engine #(.BOX(2)) dut_a (
    .in_clka(clk), .in_restart(rst), .in_start(a_start), .in_difficulty(a_diff),
    .in_enter(a_enter), .in_erase(a_erase), .in_cell_idx(a_idx), .in_value(a_val),
    .out_state(a_state), .out_fill_count(a_fill), .out_try_again(a_try),
`ifdef SUDOKU_ERR_CNT_EN
    .out_err_count(a_err),
`endif
    .out_won(a_won)
  );

  sudoku_board_engine #(.BOX(3)) dut_b (
    .in_clka(clk), .in_restart(rst), .in_start(b_start), .in_difficulty(b_diff),
    .in_enter(b_enter), .in_erase(b_erase), .in_cell_idx(b_idx), .in_value(b_val),
    .out_state(b_state), .out_fill_count(b_fill), .out_try_again(b_try),
`ifdef SUDOKU_ERR_CNT_EN
    .out_err_count(b_err),
`endif
    .out_won(b_won)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    string tag;
    logic  exp_try;
    int    exp_fill;
    int    exp_state;
    logic  exp_won;
  } exp_t;
  exp_t sb[$];

  function automatic int tb_sol(input int box, input int r, input int c);
    return (box * (r % box) + r / box + c) % (box * box);
  endfunction

  function automatic logic [31:0] st(input bit b);   return b ? 32'(b_state) : 32'(a_state); endfunction
  function automatic logic [31:0] fl(input bit b);   return b ? 32'(b_fill)  : 32'(a_fill);  endfunction
  function automatic logic [31:0] tr(input bit b);   return b ? 32'(b_try)   : 32'(a_try);   endfunction
  function automatic logic [31:0] wn(input bit b);   return b ? 32'(b_won)   : 32'(a_won);   endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_game(input bit b, input int d, input int exp_cyc, input int exp_fill,
                            input string tag);
    int n;
    if (b) begin b_start = 1'b1; b_diff = 2'(d); end
    else   begin a_start = 1'b1; a_diff = 2'(d); end
    tick();
    a_start = 1'b0;
    b_start = 1'b0;
    chk({tag, "_load"}, st(b), 1);
    n = 0;
    while (st(b) == 1 && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_load_cycles"}, n, exp_cyc);
    chk({tag, "_play"}, st(b), 2);
    chk({tag, "_fill"}, fl(b), exp_fill);
  endtask

  // Drive one enter pulse; the expected response is queued before driving.
  task automatic enter(input bit b, input string tag, input int idx, input int val, input bit er,
                       input bit rej, input int fill, input int state);
    exp_t e;
    e.tag = tag; e.exp_try = rej; e.exp_fill = fill; e.exp_state = state; e.exp_won = 1'b0;
    sb.push_back(e);
    if (b) begin b_enter = 1'b1; b_idx = 7'(idx); b_val = 4'(val); b_erase = er; end
    else   begin a_enter = 1'b1; a_idx = 4'(idx); a_val = 2'(val); a_erase = er; end
    tick();
    a_enter = 1'b0; b_enter = 1'b0; a_erase = 1'b0; b_erase = 1'b0;
    e = sb.pop_front();
    chk({e.tag, "_try"}, tr(b), 32'(e.exp_try));
    chk({e.tag, "_fill"}, fl(b), e.exp_fill);
    chk({e.tag, "_state"}, st(b), e.exp_state);
  endtask

  // Wait for the board check to finish and compare outcome and latency.
  task automatic await_check(input bit b, input string tag, input bit pass, input int exp_lat);
    exp_t e;
    int   lat;
    bit   seen;
    e.tag = tag; e.exp_try = !pass; e.exp_fill = 0; e.exp_state = pass ? 4 : 2; e.exp_won = pass;
    sb.push_back(e);
    lat  = 0;
    seen = 1'b0;
    while (lat < 200) begin
      tick();
      lat++;
      if (st(b) == 3) seen = 1'b1;
      else if (seen) break;
    end
    e = sb.pop_front();
    chk({e.tag, "_latency"}, lat, exp_lat);
    chk({e.tag, "_state"}, st(b), e.exp_state);
    chk({e.tag, "_won"}, wn(b), 32'(e.exp_won));
    chk({e.tag, "_try"}, tr(b), 32'(e.exp_try));
    if (!pass) begin
      tick();
      chk({e.tag, "_try_end"}, tr(b), 0);
    end
  endtask

  task automatic fill_diag(input string tag, input int v0);
    enter(0, {tag, "_d0"},  0,  v0, 0, 0, 13, 2);
    enter(0, {tag, "_d5"},  5,  3,  0, 0, 14, 2);
    enter(0, {tag, "_d10"}, 10, 3,  0, 0, 15, 2);
    enter(0, {tag, "_d15"}, 15, 2,  0, 0, 16, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    a_start = 0; a_enter = 0; a_erase = 0; a_diff = 0; a_idx = 0; a_val = 0;
    b_start = 0; b_enter = 0; b_erase = 0; b_diff = 0; b_idx = 0; b_val = 0;
    tick();
    tick();
    chk("rst_state", st(0), 0);
    chk("rst_fill", fl(0), 0);
    chk("rst_won", wn(0), 0);
    chk("rst_try", tr(0), 0);
    chk("rst_b_state", st(1), 0);
`ifdef SUDOKU_ERR_CNT_EN
    chk("rst_err", 32'(a_err), 0);
`endif
    rst = 1'b0;
    tick();

    // Winning diff0 game
    start_game(0, 0, 16, 12, "t1");
    fill_diag("t1", 0);
    await_check(0, "t1_check", 1'b1, 13);

    // Locked cells reject writes and erases
    start_game(0, 0, 16, 12, "t2");
    enter(0, "t2_locked_wr", 1, 2, 0, 1, 12, 2);
    enter(0, "t2_locked_er", 2, 0, 1, 1, 12, 2);

    // Wrong diagonal fails, fix it and win (also proves cell 1 kept its value)
    fill_diag("t3", 1);
    await_check(0, "t3_fail", 1'b0, 13);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("t3_start_in_play_state", st(0), 2);
    chk("t3_start_in_play_try", tr(0), 0);
    enter(0, "t3_erase0", 0, 0, 1, 0, 15, 2);
    enter(0, "t3_fix0", 0, 0, 0, 0, 16, 2);
    await_check(0, "t3_win", 1'b1, 13);
    enter(0, "t3_enter_in_won", 0, 0, 1, 0, 16, 4);

    // Given counts per difficulty; overwrite and erase bookkeeping
    start_game(0, 1, 16, 8, "diff1");
    do_restart();
    start_game(0, 2, 16, 4, "diff2");
    do_restart();
    start_game(0, 3, 16, 0, "diff3");
    enter(0, "d3_write", 3, 1, 0, 0, 1, 2);
    enter(0, "d3_overwrite", 3, 2, 0, 0, 1, 2);
    enter(0, "d3_erase", 3, 0, 1, 0, 0, 2);
    enter(0, "d3_erase_empty", 3, 0, 1, 0, 0, 2);
    do_restart();

    // Restart in the middle of a check
    start_game(0, 0, 16, 12, "t4");
    fill_diag("t4", 0);
    n = 0;
    while (st(0) != 3 && n < 10) begin
      tick();
      n++;
    end
    chk("t4_in_check", st(0), 3);
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t4_async_state", st(0), 0);
    chk("t4_async_fill", fl(0), 0);
    chk("t4_async_won", wn(0), 0);
    #1;
    rst = 1'b0;
    tick();
    enter(0, "t4_enter_idle", 0, 0, 0, 0, 0, 0);

    // BOX=3 empty board, out-of-range index, full solve
    start_game(1, 3, 81, 0, "t5");
    enter(1, "t5_idx81", 81, 0, 0, 1, 0, 2);
    for (int i = 0; i < 81; i++)
      enter(1, "t5_fill", i, tb_sol(3, i / 9, i % 9), 0, 0, i + 1, 2);
    await_check(1, "t5_check", 1'b1, 28);

`ifdef SUDOKU_ERR_CNT_EN
    do_restart();
    start_game(0, 0, 16, 12, "t6");
    chk("t6_err_init", 32'(a_err), 0);
    enter(0, "t6_lock1", 1, 0, 0, 1, 12, 2);
    enter(0, "t6_lock2", 2, 0, 0, 1, 12, 2);
    fill_diag("t6", 1);
    await_check(0, "t6_fail", 1'b0, 13);
    chk("t6_err_three", 32'(a_err), 3);
    enter(0, "t6_erase0", 0, 0, 1, 0, 15, 2);
    enter(0, "t6_fix0", 0, 0, 0, 0, 16, 2);
    await_check(0, "t6_win", 1'b1, 13);
    chk("t6_err_kept", 32'(a_err), 3);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("t6_err_cleared", 32'(a_err), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
